// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier driving an external ALU adder, one add per cycle.
// Returns the low WIDTH bits of op_a*op_b; busy covers RUN and DONE, done pulses once.
module alu_mul_seq #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] result_q;
    logic [CntW-1:0]  cnt;
    logic             busy_q;
    logic             done_q;
    logic             last_iter;

    // Early exit once no set multiplier bits remain beyond the one consumed this cycle.
    assign last_iter = (cnt == LastCnt) || (EARLY_EXIT && ((mplier >> 1) == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            result_q <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    if (mplier[0]) begin
                        acc <= alu_out;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CntW'(1);
                    if (last_iter) begin
                        done_q <= 1'b1;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    result_q <= acc;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    // In DONE the final acc is not yet in result_q, so expose it directly.
    assign result  = (state == StDone) ? acc : result_q;
    assign alu_a   = (state == StRun) ? acc : '0;
    assign alu_b   = (state == StRun) ? mcand : '0;
    assign alu_sel = 2'b00;

endmodule
